ac_cfg_regfile: RTL and testbench

AXI-Lite slave configuration register file: the responder end of the access-control configuration master.
- Holds frame geometry and the start control for the up-sampling datapath.
- Tracks busy/done status and generates the completion interrupt.
- Sits between the AXI-Lite configuration bus and the access-control/up-sampling core, in the single clk domain.

---
 rtl/ac_cfg_regfile.sv | 218 +++++++++++++++++++++
 tb/tb_ac_cfg_regfile.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_cfg_regfile.sv
// AXI-Lite configuration register file for the access-control / up-sampling core.
// Optional macro CFG_SLVERR_EN: unmapped accesses and busy-rejected writes answer SLVERR.
module ac_cfg_regfile #(
    parameter int CRF_ADDR_WIDTH = 32,
    parameter int CRF_DATA_WIDTH = 32,
    parameter int RST_WIDTH      = 960,
    parameter int RST_HEIGHT     = 540
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CRF_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [CRF_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [CRF_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [CRF_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      cfg_start,
    output logic [15:0]               cfg_width,
    output logic [15:0]               cfg_height,
    input  logic                      up_done,
    output logic                      interrupt_updone
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef CFG_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_STATUS   = 3'd1;
    localparam logic [2:0] IDX_SRC_W    = 3'd2;
    localparam logic [2:0] IDX_SRC_H    = 3'd3;
    localparam logic [2:0] IDX_INT_EN   = 3'd4;
    localparam logic [2:0] IDX_INT_STAT = 3'd5;

    logic        ready_en_reg;
    logic        aw_held_reg;
    logic [2:0]  aw_idx_reg;
    logic        w_held_reg;
    logic [15:0] wdata_reg;
    logic [1:0]  wstrb_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic        rvalid_reg;
    logic [CRF_DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        int_en_reg;
    logic        int_stat_reg;
    logic        cfg_start_reg;
    logic        irq_reg;
    logic [15:0] width_reg;
    logic [15:0] height_reg;

    logic        aw_fire;
    logic        w_fire;
    logic        ar_fire;
    logic        wr_commit;
    logic        start_req;
    logic        start_ok;
    logic        geom_wr;
    logic        wr_reject;
    logic        done_evt;
    logic [15:0] width_next;
    logic [15:0] height_next;
    logic [CRF_DATA_WIDTH-1:0] rd_mux;
    logic        rd_err;

    // Only address bits [4:2], the low half-word and the low two strobes are meaningful.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[CRF_ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                           s_axi_araddr[CRF_ADDR_WIDTH-1:5], s_axi_araddr[1:0],
                           s_axi_wdata[CRF_DATA_WIDTH-1:16], s_axi_wstrb[3:2]};

    // ready_en_reg keeps every ready low through reset and for the release edge.
    assign s_axi_awready = ready_en_reg && !aw_held_reg && !bvalid_reg;
    assign s_axi_wready  = ready_en_reg && !w_held_reg && !bvalid_reg;
    assign s_axi_arready = ready_en_reg && !rvalid_reg;

    assign aw_fire   = s_axi_awvalid && s_axi_awready;
    assign w_fire    = s_axi_wvalid && s_axi_wready;
    assign ar_fire   = s_axi_arvalid && s_axi_arready;
    assign wr_commit = aw_held_reg && w_held_reg;

    assign start_req = wr_commit && (aw_idx_reg == IDX_CTRL) && wstrb_reg[0] && wdata_reg[0];
    assign start_ok  = start_req && !busy_reg;
    assign geom_wr   = wr_commit && ((aw_idx_reg == IDX_SRC_W) || (aw_idx_reg == IDX_SRC_H));
    assign wr_reject = (start_req && busy_reg) || (geom_wr && busy_reg)
                     || (wr_commit && (aw_idx_reg[2:1] == 2'b11));
    assign done_evt  = up_done && busy_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byte_merge
            assign width_next[gi*8 +: 8]  = wstrb_reg[gi] ? wdata_reg[gi*8 +: 8] : width_reg[gi*8 +: 8];
            assign height_next[gi*8 +: 8] = wstrb_reg[gi] ? wdata_reg[gi*8 +: 8] : height_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        rd_err = 1'b0;
        case (s_axi_araddr[4:2])
            IDX_STATUS:   rd_mux[1:0]  = {done_reg, busy_reg};
            IDX_SRC_W:    rd_mux[15:0] = width_reg;
            IDX_SRC_H:    rd_mux[15:0] = height_reg;
            IDX_INT_EN:   rd_mux[0]    = int_en_reg;
            IDX_INT_STAT: rd_mux[0]    = int_stat_reg;
            3'd6, 3'd7:   rd_err       = 1'b1;
            default:      rd_mux       = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en_reg  <= 1'b0;
            aw_held_reg   <= 1'b0;
            aw_idx_reg    <= '0;
            w_held_reg    <= 1'b0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= RESP_OKAY;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
            rresp_reg     <= RESP_OKAY;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            int_en_reg    <= 1'b0;
            int_stat_reg  <= 1'b0;
            cfg_start_reg <= 1'b0;
            irq_reg       <= 1'b0;
            width_reg     <= 16'(RST_WIDTH);
            height_reg    <= 16'(RST_HEIGHT);
        end else begin
            ready_en_reg <= 1'b1;

            if (aw_fire) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_axi_awaddr[4:2];
            end
            if (w_fire) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_wdata[15:0];
                wstrb_reg  <= s_axi_wstrb[1:0];
            end

            if (wr_commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= (SLVERR_EN && wr_reject) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end

            if (ar_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
                rresp_reg  <= (SLVERR_EN && rd_err) ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_reg && s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end

            // start_ok needs !busy and done_evt needs busy, so they never collide.
            cfg_start_reg <= start_ok;
            if (start_ok) begin
                busy_reg <= 1'b1;
                done_reg <= 1'b0;
            end else if (done_evt) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end

            if (geom_wr && !busy_reg) begin
                if (aw_idx_reg == IDX_SRC_W) width_reg <= width_next;
                else                         height_reg <= height_next;
            end

            if (wr_commit && (aw_idx_reg == IDX_INT_EN) && wstrb_reg[0])
                int_en_reg <= wdata_reg[0];

            // A completion arriving with a W1C on the same edge must not be lost.
            if (done_evt)
                int_stat_reg <= 1'b1;
            else if (wr_commit && (aw_idx_reg == IDX_INT_STAT) && wstrb_reg[0] && wdata_reg[0])
                int_stat_reg <= 1'b0;

            irq_reg <= int_en_reg && int_stat_reg;
        end
    end

    assign s_axi_bvalid     = bvalid_reg;
    assign s_axi_bresp      = bresp_reg;
    assign s_axi_rvalid     = rvalid_reg;
    assign s_axi_rdata      = rdata_reg;
    assign s_axi_rresp      = rresp_reg;
    assign cfg_start        = cfg_start_reg;
    assign cfg_width        = width_reg;
    assign cfg_height       = height_reg;
    assign interrupt_updone = irq_reg;

endmodule

// File: tb/tb_ac_cfg_regfile.sv
// Randomized bench for ac_cfg_regfile against a register-level reference model.
module tb_ac_cfg_regfile;

`ifdef CFG_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        cfg_start;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic        up_done;
    logic        interrupt_updone;

    ac_cfg_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .cfg_start(cfg_start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .up_done(up_done),
        .interrupt_updone(interrupt_updone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int start_pulses = 0;

    always @(negedge clk) if (cfg_start === 1'b1) start_pulses++;

    // Reference model: one variable per architectural field.
    logic [15:0] m_w, m_h;
    bit m_busy, m_done, m_int_en, m_int_stat;
    int m_starts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_w = 16'd960; m_h = 16'd540;
        m_busy = 0; m_done = 0; m_int_en = 0; m_int_stat = 0;
    endtask

    task automatic model_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] exp_resp);
        bit err = 0;
        case (idx)
            3'd0: if (s[0] && d[0]) begin
                      if (m_busy) err = 1;
                      else begin m_busy = 1; m_done = 0; m_starts++; end
                  end
            3'd2: if (m_busy) err = 1;
                  else begin
                      if (s[0]) m_w[7:0]  = d[7:0];
                      if (s[1]) m_w[15:8] = d[15:8];
                  end
            3'd3: if (m_busy) err = 1;
                  else begin
                      if (s[0]) m_h[7:0]  = d[7:0];
                      if (s[1]) m_h[15:8] = d[15:8];
                  end
            3'd4: if (s[0]) m_int_en = d[0];
            3'd5: if (s[0] && d[0]) m_int_stat = 0;
            3'd6, 3'd7: err = 1;
            default: ;
        endcase
        exp_resp = (SLVERR && err) ? 2'b10 : 2'b00;
    endtask

    task automatic model_read(input logic [2:0] idx, output logic [31:0] exp_data,
                              output logic [1:0] exp_resp);
        exp_data = 32'h0;
        exp_resp = 2'b00;
        case (idx)
            3'd1: exp_data = {30'h0, m_done, m_busy};
            3'd2: exp_data = {16'h0, m_w};
            3'd3: exp_data = {16'h0, m_h};
            3'd4: exp_data = {31'h0, m_int_en};
            3'd5: exp_data = {31'h0, m_int_stat};
            3'd6, 3'd7: exp_resp = SLVERR ? 2'b10 : 2'b00;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_addr(input logic [2:0] idx);
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFE3;
        return a | {27'h0, idx, 2'b00};
    endfunction

    // Full write transaction, then the model is advanced and every visible output compared.
    task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly);
        bit aw_done, w_done, af, wf;
        int c, lat;
        logic [1:0] resp, exp_resp;
        s_axi_awaddr = rand_addr(idx);
        s_axi_wdata = d;
        s_axi_wstrb = s;
        s_axi_awvalid = (aw_dly == 0);
        s_axi_wvalid = (w_dly == 0);
        aw_done = 0; w_done = 0; c = 0;
        while (!(aw_done && w_done) && c < 40) begin
            @(negedge clk);
            af = s_axi_awvalid && s_axi_awready;
            wf = s_axi_wvalid && s_axi_wready;
            @(posedge clk); #1;
            if (af) begin aw_done = 1; s_axi_awvalid = 0; end
            if (wf) begin w_done = 1; s_axi_wvalid = 0; end
            c++;
            if (!aw_done && c == aw_dly) s_axi_awvalid = 1;
            if (!w_done && c == w_dly) s_axi_wvalid = 1;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        check("wr_accept", 32'(aw_done && w_done), 32'd1);
        lat = 0;
        while (!s_axi_bvalid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("wr_bvalid_latency", 32'(lat), 32'd1);
        resp = s_axi_bresp;
        s_axi_bready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0;
        model_write(idx, d, s, exp_resp);
        $display("write off=0x%02h data=0x%08h strb=0x%h bresp=%0d", {idx, 2'b00}, d, s, resp);
        check("wr_bresp", 32'(resp), 32'(exp_resp));
        check("cfg_width", 32'(cfg_width), 32'(m_w));
        check("cfg_height", 32'(cfg_height), 32'(m_h));
        check("start_pulses", 32'(start_pulses), 32'(m_starts));
        check("irq_after_wr", 32'(interrupt_updone), 32'(m_int_en && m_int_stat));
    endtask

    task automatic rd(input logic [2:0] idx);
        bit fired;
        int c;
        logic [31:0] data, exp_data;
        logic [1:0] resp, exp_resp;
        model_read(idx, exp_data, exp_resp);
        s_axi_araddr = rand_addr(idx);
        s_axi_arvalid = 1;
        fired = 0; c = 0;
        while (!fired && c < 40) begin
            @(negedge clk);
            fired = s_axi_arvalid && s_axi_arready;
            @(posedge clk); #1;
            c++;
        end
        s_axi_arvalid = 0;
        check("rd_accept", 32'(fired), 32'd1);
        check("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_rready = 0;
        $display("read  off=0x%02h rdata=0x%08h rresp=%0d", {idx, 2'b00}, data, resp);
        check("rd_data", data, exp_data);
        check("rd_resp", 32'(resp), 32'(exp_resp));
    endtask

    task automatic pulse_done();
        bit irq_before;
        irq_before = m_int_en && m_int_stat;
        up_done = 1;
        @(posedge clk); #1;
        up_done = 0;
        if (m_busy) begin m_busy = 0; m_done = 1; m_int_stat = 1; end
        $display("up_done pulse busy_after=%0d int_stat=%0d", m_busy, m_int_stat);
        check("irq_same_edge", 32'(interrupt_updone), 32'(irq_before));
        @(posedge clk); #1;
        check("irq_next_edge", 32'(interrupt_updone), 32'(m_int_en && m_int_stat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] held_data;
        logic [2:0] idx;
        int op, dly;

        rst_n = 0; up_done = 0;
        s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        m_starts = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready", 32'(s_axi_wready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_cfg_start", 32'(cfg_start), 32'd0);
        check("rst_irq", 32'(interrupt_updone), 32'd0);
        check("rst_width", 32'(cfg_width), 32'd960);
        check("rst_height", 32'(cfg_height), 32'd540);
        rst_n = 1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        rd(3'd2);
        rd(3'd3);

        // W leads AW by three cycles, then a partial-strobe update.
        wr(3'd2, 32'h0000_0780, 4'hF, 3, 0);
        check("width_1920", 32'(cfg_width), 32'd1920);
        wr(3'd2, 32'h0000_1234, 4'h1, 0, 0);
        check("width_0734", 32'(cfg_width), 32'h0734);

        wr(3'd4, 32'h1, 4'hF, 0, 0);
        wr(3'd0, 32'h1, 4'h1, 0, 0);
        rd(3'd1);
        wr(3'd0, 32'h1, 4'h1, 1, 0);
        wr(3'd3, 32'h0000_0400, 4'h3, 0, 2);
        rd(3'd1);
        pulse_done();
        rd(3'd1);
        rd(3'd5);
        wr(3'd5, 32'h1, 4'h1, 0, 0);
        check("irq_cleared", 32'(interrupt_updone), 32'd0);

        // W1C to INT_STAT commits on the same edge as up_done.
        wr(3'd0, 32'h1, 4'h1, 0, 0);
        s_axi_awaddr = 32'h14; s_axi_wdata = 32'h1; s_axi_wstrb = 4'h1;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(negedge clk);
        check("same_edge_ready", 32'(s_axi_awready && s_axi_wready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; up_done = 1;
        @(posedge clk); #1;
        up_done = 0;
        m_busy = 0; m_done = 1; m_int_stat = 1;
        check("same_edge_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0;
        check("same_edge_irq", 32'(interrupt_updone), 32'd1);
        rd(3'd5);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            idx = 3'($urandom_range(0, 7));
            if (op <= 3) begin
                dly = $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) wr(idx, $urandom, 4'($urandom), dly, 0);
                else                           wr(idx, $urandom, 4'($urandom), 0, dly);
            end else if (op <= 6) begin
                rd(idx);
            end else if (op <= 8) begin
                pulse_done();
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Back-pressure on both response channels, then reset in the middle of it.
        pulse_done();
        s_axi_awaddr = 32'h0C; s_axi_wdata = 32'h0000_0100; s_axi_wstrb = 4'h3;
        s_axi_araddr = 32'h08;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
        @(posedge clk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        held_data = {16'h0, m_w};
        @(posedge clk); #1;
        m_h = 16'h0100;
        check("bp_height", 32'(cfg_height), 32'h0100);
        for (int k = 0; k < 5; k++) begin
            check("bp_bvalid", 32'(s_axi_bvalid), 32'd1);
            check("bp_rvalid", 32'(s_axi_rvalid), 32'd1);
            check("bp_rdata", s_axi_rdata, held_data);
            check("bp_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
            @(posedge clk); #1;
        end
        rst_n = 0;
        @(posedge clk); #1;
        check("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("mid_rst_height", 32'(cfg_height), 32'd540);
        check("mid_rst_width", 32'(cfg_width), 32'd960);
        check("mid_rst_irq", 32'(interrupt_updone), 32'd0);
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        rd(3'd3);
        rd(3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
